axi_lite_ipif_bridge: RTL and testbench



---
 rtl/axi_lite_ipif_bridge_pkg.sv | 16 +
 rtl/axi_lite_ipif_bridge_if.sv | 58 +++++
 rtl/axi_lite_arbiter.sv | 30 +++
 rtl/axi_lite_ipif_bridge.sv | 216 +++++++++++++++++++++
 tb/tb_axi_lite_ipif_bridge.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_ipif_bridge_pkg.sv
// Shared constants and FSM encoding for the AXI4-Lite to IPIF bridge.
package axi_lite_ipif_bridge_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

endpackage

// File: rtl/axi_lite_ipif_bridge_if.sv
// AXI4-Lite slave channels plus the IPIF master side of the bridge.
interface axi_lite_ipif_bridge_if #(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    logic                            Bus2IP_Clk;
    logic                            Bus2IP_Resetn;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   Bus2IP_Addr;
    logic                            Bus2IP_CS;
    logic                            Bus2IP_RNW;
    logic [C_S_AXI_DATA_WIDTH-1:0]   Bus2IP_Data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] Bus2IP_BE;
    logic [C_S_AXI_DATA_WIDTH-1:0]   IP2Bus_Data;
    logic                            IP2Bus_RdAck;
    logic                            IP2Bus_WrAck;
    logic                            IP2Bus_Error;

    // Bridge view: AXI slave, IPIF master.
    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output Bus2IP_Clk, Bus2IP_Resetn, Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW,
        output Bus2IP_Data, Bus2IP_BE,
        input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
    );

    // Environment view: AXI master and IPIF register-file stage.
    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  Bus2IP_Clk, Bus2IP_Resetn, Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW,
        input  Bus2IP_Data, Bus2IP_BE,
        output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
    );

endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-way read/write round-robin; the history bit only moves on contested grants.
module axi_lite_arbiter (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rd_req_i,
    input  logic wr_req_i,
    output logic grant_rd_o,
    output logic grant_wr_o
);

    logic last_was_write_q, last_was_write_d;

    always_comb begin
        grant_wr_o       = wr_req_i && (!rd_req_i || !last_was_write_q);
        grant_rd_o       = rd_req_i && (!wr_req_i || last_was_write_q);
        last_was_write_d = last_was_write_q;
        if (rd_req_i && wr_req_i) begin
            last_was_write_d = grant_wr_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_was_write_q <= 1'b0;
        end else begin
            last_was_write_q <= last_was_write_d;
        end
    end

endmodule

// File: rtl/axi_lite_ipif_bridge.sv
// AXI4-Lite slave that serialises reads/writes into single IPIF accesses with
// window decode, ack-to-response conversion and an ack timeout.
module axi_lite_ipif_bridge
    import axi_lite_ipif_bridge_pkg::*;
#(
    parameter int unsigned                  C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned                  C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR        = 32'hFFFFFFFF,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_HIGHADDR        = 32'h00000000,
    parameter int unsigned                  C_TIMEOUT          = 16
) (
    input logic                   S_AXI_ACLK,
    input logic                   S_AXI_ARESETN,
    axi_lite_ipif_bridge_if.slave bus
);

    localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [7:0]  TimeoutLast = 8'(C_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            aw_held_q, aw_held_d;
    logic [AW-1:0]   aw_addr_q, aw_addr_d;
    logic            w_held_q, w_held_d;
    logic [DW-1:0]   w_data_q, w_data_d;
    logic [SW-1:0]   w_strb_q, w_strb_d;
    logic            cs_q, cs_d;
    logic            rnw_q, rnw_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [SW-1:0]   be_q, be_d;
    logic [1:0]      resp_q, resp_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            bvalid_q, bvalid_d;
    logic            rvalid_q, rvalid_d;
    logic [7:0]      timer_q, timer_d;

    logic            idle;
    logic            awready, wready, arready;
    logic            aw_hs, w_hs, wr_pend;
    logic            grant_rd, grant_wr;
    logic [AW-1:0]   wr_addr, launch_addr;
    logic [DW-1:0]   wr_data;
    logic [SW-1:0]   wr_strb;
    logic            in_win, ack;

    // Gate with reset so every READY reads 0 while reset is held.
    assign idle    = (state_q == StIdle) && S_AXI_ARESETN;
    assign awready = idle && !aw_held_q;
    assign wready  = idle && !w_held_q;
    assign aw_hs   = awready && bus.S_AXI_AWVALID;
    assign w_hs    = wready && bus.S_AXI_WVALID;
    assign wr_pend = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign arready = idle && !grant_wr;

    axi_lite_arbiter u_arbiter (
        .clk_i      (S_AXI_ACLK),
        .rst_ni     (S_AXI_ARESETN),
        .rd_req_i   (idle && bus.S_AXI_ARVALID),
        .wr_req_i   (idle && wr_pend),
        .grant_rd_o (grant_rd),
        .grant_wr_o (grant_wr)
    );

    assign wr_addr     = aw_held_q ? aw_addr_q : bus.S_AXI_AWADDR;
    assign wr_data     = w_held_q ? w_data_q : bus.S_AXI_WDATA;
    assign wr_strb     = w_held_q ? w_strb_q : bus.S_AXI_WSTRB;
    assign launch_addr = grant_wr ? wr_addr : bus.S_AXI_ARADDR;
    assign in_win      = (launch_addr >= C_BASEADDR) && (launch_addr <= C_HIGHADDR);
    assign ack         = rnw_q ? bus.IP2Bus_RdAck : bus.IP2Bus_WrAck;

    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        cs_d      = cs_q;
        rnw_d     = rnw_q;
        addr_d    = addr_q;
        data_d    = data_q;
        be_d      = be_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        timer_d   = timer_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = bus.S_AXI_AWADDR;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = bus.S_AXI_WDATA;
            w_strb_d = bus.S_AXI_WSTRB;
        end

        unique case (state_q)
            StIdle: begin
                if (grant_wr || grant_rd) begin
                    addr_d = launch_addr;
                    rnw_d  = grant_rd;
                    if (grant_wr) begin
                        data_d = wr_data;
                        be_d   = wr_strb;
                    end
                    if (in_win) begin
                        state_d = StAccess;
                        cs_d    = 1'b1;
                        timer_d = '0;
                    end else begin
                        state_d  = StResp;
                        resp_d   = RESP_DECERR;
                        bvalid_d = grant_wr;
                        rvalid_d = grant_rd;
                        if (grant_rd) begin
                            rdata_d = '0;
                        end
                    end
                end
            end
            StAccess: begin
                timer_d = timer_q + 8'd1;
                if (ack) begin
                    state_d  = StResp;
                    cs_d     = 1'b0;
                    resp_d   = bus.IP2Bus_Error ? RESP_SLVERR : RESP_OKAY;
                    bvalid_d = !rnw_q;
                    rvalid_d = rnw_q;
                    if (rnw_q) begin
                        rdata_d = bus.IP2Bus_Data;
                    end
                end else if (timer_q == TimeoutLast) begin
                    state_d  = StResp;
                    cs_d     = 1'b0;
                    resp_d   = RESP_SLVERR;
                    bvalid_d = !rnw_q;
                    rvalid_d = rnw_q;
                    if (rnw_q) begin
                        rdata_d = TIMEOUT_RDATA;
                    end
                end
            end
            StResp: begin
                if (rnw_q && bus.S_AXI_RREADY) begin
                    state_d  = StIdle;
                    rvalid_d = 1'b0;
                end else if (!rnw_q && bus.S_AXI_BREADY) begin
                    state_d   = StIdle;
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= StIdle;
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            cs_q      <= 1'b0;
            rnw_q     <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            resp_q    <= RESP_OKAY;
            rdata_q   <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            cs_q      <= cs_d;
            rnw_q     <= rnw_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            be_q      <= be_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            timer_q   <= timer_d;
        end
    end

    assign bus.S_AXI_AWREADY = awready;
    assign bus.S_AXI_WREADY  = wready;
    assign bus.S_AXI_ARREADY = arready;
    assign bus.S_AXI_BRESP   = resp_q;
    assign bus.S_AXI_BVALID  = bvalid_q;
    assign bus.S_AXI_RRESP   = resp_q;
    assign bus.S_AXI_RDATA   = rdata_q;
    assign bus.S_AXI_RVALID  = rvalid_q;
    assign bus.Bus2IP_Clk    = S_AXI_ACLK;
    assign bus.Bus2IP_Resetn = S_AXI_ARESETN;
    assign bus.Bus2IP_Addr   = addr_q;
    assign bus.Bus2IP_CS     = cs_q;
    assign bus.Bus2IP_RNW    = rnw_q;
    assign bus.Bus2IP_Data   = data_q;
    assign bus.Bus2IP_BE     = be_q;

endmodule

// File: tb/tb_axi_lite_ipif_bridge.sv
// Directed bench: AXI master stimulus plus a small 1-cycle-ack register-file stage.
module tb_axi_lite_ipif_bridge;

    localparam logic [31:0] Base = 32'h4000_0000;
    localparam logic [31:0] High = 32'h4000_0FFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_ipif_bridge_if #(.C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32)) bus ();

    axi_lite_ipif_bridge #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (32),
        .C_BASEADDR         (Base),
        .C_HIGHADDR         (High),
        .C_TIMEOUT          (16)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .bus           (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register-file stage: acks one cycle after seeing CS; mode 1 never acks, mode 2 errors.
    int          slave_mode = 0;
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (bus.Bus2IP_CS && !bus.Bus2IP_RNW) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.Bus2IP_BE[b]) mem[bus.Bus2IP_Addr[5:2]][8*b +: 8] <= bus.Bus2IP_Data[8*b +: 8];
            end
        end
        bus.IP2Bus_Data  <= mem[bus.Bus2IP_Addr[5:2]];
        bus.IP2Bus_RdAck <= bus.Bus2IP_CS && bus.Bus2IP_RNW && (slave_mode != 1);
        bus.IP2Bus_WrAck <= bus.Bus2IP_CS && !bus.Bus2IP_RNW && (slave_mode != 1);
        bus.IP2Bus_Error <= bus.Bus2IP_CS && (slave_mode == 2);
    end

    // CS monitor: rising edges, high cycles, and RNW of each access in order.
    logic cs_prev = 1'b0;
    int   cs_rises = 0;
    int   cs_high = 0;
    logic order_q[$];
    always @(posedge clk) begin
        cs_prev <= bus.Bus2IP_CS;
        if (bus.Bus2IP_CS) cs_high <= cs_high + 1;
        if (bus.Bus2IP_CS && !cs_prev) begin
            cs_rises <= cs_rises + 1;
            order_q.push_back(bus.Bus2IP_RNW);
        end
    end

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        logic aw_ok, w_ok;
        int   n;
        aw_ok = 1'b0;
        w_ok  = 1'b0;
        n     = 0;
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        while (!(aw_ok && w_ok) && n < 64) begin
            @(negedge clk);
            if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) aw_ok = 1'b1;
            if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) w_ok = 1'b1;
            tick();
            if (aw_ok) bus.S_AXI_AWVALID = 1'b0;
            if (w_ok) bus.S_AXI_WVALID = 1'b0;
            n++;
        end
        while (!bus.S_AXI_BVALID && n < 64) begin
            tick();
            n++;
        end
        check("wr_bvalid_seen", {31'd0, bus.S_AXI_BVALID}, 32'd1);
        resp = bus.S_AXI_BRESP;
        tick();
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic ar_ok;
        int   n;
        ar_ok = 1'b0;
        n     = 0;
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        while (!ar_ok && n < 64) begin
            @(negedge clk);
            if (bus.S_AXI_ARREADY) ar_ok = 1'b1;
            tick();
            if (ar_ok) bus.S_AXI_ARVALID = 1'b0;
            n++;
        end
        while (!bus.S_AXI_RVALID && n < 64) begin
            tick();
            n++;
        end
        check("rd_rvalid_seen", {31'd0, bus.S_AXI_RVALID}, 32'd1);
        d    = bus.S_AXI_RDATA;
        resp = bus.S_AXI_RRESP;
        tick();
    endtask

    logic [1:0]  wresp, rresp;
    logic [31:0] rdata;
    int          base_rises, base_high, base_idx;

    initial begin
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
        check("rst_wready", {31'd0, bus.S_AXI_WREADY}, 32'd0);
        check("rst_arready", {31'd0, bus.S_AXI_ARREADY}, 32'd0);
        check("rst_valids", {30'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'd0);
        check("rst_cs_rnw", {30'd0, bus.Bus2IP_CS, bus.Bus2IP_RNW}, 32'd1);
        check("rst_addr", bus.Bus2IP_Addr, 32'd0);
        check("rst_rdata", bus.S_AXI_RDATA, 32'd0);
        check("rst_resetn", {31'd0, bus.Bus2IP_Resetn}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);

        // Cycle-exact write then read back
        bus.S_AXI_AWADDR = Base + 32'h4; bus.S_AXI_WDATA = 32'hA5A5_0001; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        check("wr_c1_cs", {31'd0, bus.Bus2IP_CS}, 32'd1);
        check("wr_c1_rnw", {31'd0, bus.Bus2IP_RNW}, 32'd0);
        check("wr_c1_addr", bus.Bus2IP_Addr, 32'h4000_0004);
        check("wr_c1_data", bus.Bus2IP_Data, 32'hA5A5_0001);
        check("wr_c1_be", {28'd0, bus.Bus2IP_BE}, 32'hF);
        tick();
        check("wr_c2_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd0);
        tick();
        check("wr_c3_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
        check("wr_c3_bresp", {30'd0, bus.S_AXI_BRESP}, 32'd0);
        check("wr_c3_cs", {31'd0, bus.Bus2IP_CS}, 32'd0);
        tick();
        check("wr_c4_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd0);

        bus.S_AXI_ARADDR = Base + 32'h4; bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        check("rd_c1_cs_rnw", {30'd0, bus.Bus2IP_CS, bus.Bus2IP_RNW}, 32'd3);
        tick(); tick();
        check("rd_c3_rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd1);
        check("rd_c3_rdata", bus.S_AXI_RDATA, 32'hA5A5_0001);
        check("rd_c3_rresp", {30'd0, bus.S_AXI_RRESP}, 32'd0);
        tick();

        // W three cycles ahead of AW
        base_rises = cs_rises;
        bus.S_AXI_WDATA = 32'h1234_5678; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        check("early_w_wready", {31'd0, bus.S_AXI_WREADY}, 32'd1);
        tick();
        bus.S_AXI_WVALID = 1'b0;
        tick(); tick();
        check("early_w_no_cs", cs_rises - base_rises, 32'd0);
        check("early_w_held", {31'd0, bus.S_AXI_WREADY}, 32'd0);
        bus.S_AXI_AWADDR = Base + 32'h8; bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        check("late_aw_cs", {31'd0, bus.Bus2IP_CS}, 32'd1);
        check("late_aw_data", bus.Bus2IP_Data, 32'h1234_5678);
        tick(); tick();
        check("late_aw_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
        check("late_aw_bresp", {30'd0, bus.S_AXI_BRESP}, 32'd0);
        tick();
        check("late_aw_one_cs", cs_rises - base_rises, 32'd1);
        axi_read(Base + 32'h8, rdata, rresp);
        check("late_aw_readback", rdata, 32'h1234_5678);

        // Two ties: first goes to the write, second to the read
        base_idx = order_q.size();
        fork
            axi_write(Base + 32'hC, 32'hCAFE_0003, 4'hF, wresp);
            axi_read(Base + 32'h4, rdata, rresp);
        join
        check("tie1_count", order_q.size() - base_idx, 32'd2);
        check("tie1_first_write", {31'd0, order_q[base_idx]}, 32'd0);
        check("tie1_second_read", {31'd0, order_q[base_idx+1]}, 32'd1);
        check("tie1_rdata", rdata, 32'hA5A5_0001);
        base_idx = order_q.size();
        fork
            axi_write(Base + 32'h10, 32'hBEEF_0004, 4'h3, wresp);
            axi_read(Base + 32'hC, rdata, rresp);
        join
        check("tie2_first_read", {31'd0, order_q[base_idx]}, 32'd1);
        check("tie2_second_write", {31'd0, order_q[base_idx+1]}, 32'd0);
        check("tie2_rdata", rdata, 32'hCAFE_0003);
        axi_read(Base + 32'h10, rdata, rresp);
        check("tie2_strb_write", rdata, 32'h0000_0004);

        // Out-of-window decode
        base_rises = cs_rises;
        bus.S_AXI_ARADDR = High + 32'h1; bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        check("decerr_rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd1);
        check("decerr_rresp", {30'd0, bus.S_AXI_RRESP}, 32'd3);
        check("decerr_rdata", bus.S_AXI_RDATA, 32'd0);
        tick();
        axi_write(Base - 32'h4, 32'h1, 4'hF, wresp);
        check("decerr_bresp", {30'd0, wresp}, 32'd3);
        check("decerr_no_cs", cs_rises - base_rises, 32'd0);
        axi_read(High - 32'h3, rdata, rresp);
        check("high_edge_rresp", {30'd0, rresp}, 32'd0);
        check("high_edge_cs", cs_rises - base_rises, 32'd1);

        // Silent slave: timeout
        slave_mode = 1;
        base_high  = cs_high;
        axi_read(Base + 32'h14, rdata, rresp);
        check("timeout_cs_cycles", cs_high - base_high, 32'd16);
        check("timeout_rresp", {30'd0, rresp}, 32'd2);
        check("timeout_rdata", rdata, 32'hDEADBEEF);

        // Error with ack, then reset in the middle of the next access
        slave_mode = 2;
        axi_write(Base + 32'h18, 32'h1111_2222, 4'hF, wresp);
        check("slverr_bresp", {30'd0, wresp}, 32'd2);
        slave_mode = 0;
        bus.S_AXI_AWADDR = Base + 32'h1C; bus.S_AXI_WDATA = 32'h5555_AAAA;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        check("mid_rst_cs_before", {31'd0, bus.Bus2IP_CS}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_cs", {31'd0, bus.Bus2IP_CS}, 32'd0);
        check("mid_rst_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd0);
        check("mid_rst_rnw_addr", {bus.Bus2IP_Addr[30:0], bus.Bus2IP_RNW}, 32'd1);
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        check("mid_rst_no_resp", {30'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'd0);
        axi_write(Base + 32'h20, 32'h7777_8888, 4'hF, wresp);
        check("post_rst_bresp", {30'd0, wresp}, 32'd0);
        axi_read(Base + 32'h20, rdata, rresp);
        check("post_rst_rdata", rdata, 32'h7777_8888);
        check("post_rst_rresp", {30'd0, rresp}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
